fft_frame_feeder: RTL

Synthesizable frame sequencer that holds `FRAMES` complex input frames of `N` points each and streams them into an FFT core. Each frame is preceded by a one-cycle `START` pulse, so the block drives a core's `START`/`DR`/`DI` inputs directly. Compared with the fixed 32-point, 3-frame stimulus the team used earlier, this block adds:

- parametrised width, size and frame count;
- a host load port;
- downstream stall (`ready`);
- status outputs;
- optional bit-reversed read order.

---
 rtl/fft_feeder_pkg.sv | 44 ++++
 rtl/fft_feeder_addr_gen.sv | 75 +++++++
 rtl/fft_frame_feeder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fft_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_feeder_pkg
// Brief    : Shared types and helpers for the FFT frame feeder: FSM state
//            encoding, clog2, index bit-reversal and size limits.
// Revision : 1.0 - initial release
// ============================================================================
package fft_feeder_pkg;

    localparam int N_MAX      = 1024;
    localparam int FRAMES_MAX = 16;

    // Widest in-frame index the bit-reverse helper handles (log2 of N_MAX).
    localparam int c_bitrev_w = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SOF    = 2'd1,
        STREAM = 2'd2,
        FIN    = 2'd3
    } feeder_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Reverse the low 'bits' bits of value; upper bits of the result are zero.
    function automatic logic [c_bitrev_w-1:0] bitrev(input logic [c_bitrev_w-1:0] value,
                                                     input int bits);
        logic [c_bitrev_w-1:0] rev;
        rev = {<<{value}};
        return rev >> (c_bitrev_w - bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_feeder_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : fft_feeder_addr_gen
// Brief    : Index/frame counters, terminal-count flags and read-address
//            formation for the frame feeder. With FEEDER_BITREV_EN defined the
//            in-frame index is bit-reversed before forming the address.
// Revision : 1.0 - initial release
// ============================================================================
module fft_feeder_addr_gen
    import fft_feeder_pkg::*;
#(
    parameter int N      = 32,
    parameter int FRAMES = 3,
    parameter int AW     = clog2(N * FRAMES)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    input  logic          adv_idx,
    input  logic          adv_frame,
    output logic          last_idx,
    output logic          last_frame,
    output logic [AW-1:0] rd_addr
);

    localparam int c_log_n = clog2(N);
    // One spare bit so FRAMES=1 still gets a legal one-bit counter.
    localparam int c_fw    = clog2(FRAMES + 1);

    logic [c_log_n-1:0] idx_q, idx_d;
    logic [c_fw-1:0]    frame_q, frame_d;
    logic [c_log_n-1:0] idx_rd;

    assign last_idx   = (idx_q == c_log_n'(N - 1));
    assign last_frame = (frame_q == c_fw'(FRAMES - 1));

    // Next counter values: clear at run start, step index per sample, frame per SOF.
    always_comb begin
        idx_d   = idx_q;
        frame_d = frame_q;
        if (clr) begin
            idx_d   = '0;
            frame_d = '0;
        end else begin
            if (adv_idx) begin
                idx_d = last_idx ? '0 : idx_q + c_log_n'(1);
            end
            if (adv_frame) begin
                frame_d = frame_q + c_fw'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idx_q   <= '0;
            frame_q <= '0;
        end else begin
            idx_q   <= idx_d;
            frame_q <= frame_d;
        end
    end

`ifdef FEEDER_BITREV_EN
    assign idx_rd = c_log_n'(bitrev(c_bitrev_w'(idx_q), c_log_n));
`else
    assign idx_rd = idx_q;
`endif

    // N is a power of two, so frame*N + index is a plain concatenation.
    assign rd_addr = AW'({frame_q, idx_rd});

endmodule
`default_nettype wire

// File: rtl/fft_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_feeder
// Brief    : Holds FRAMES complex frames of N points and streams them into an
//            FFT core: a one-cycle START before each frame, then N samples on
//            DR/DI qualified by DVAL, with downstream stall via ready.
//            Optional FEEDER_BITREV_EN selects bit-reversed in-frame order.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_feeder
    import fft_feeder_pkg::*;
#(
    parameter int  W      = 16,
    parameter int  N      = 32,
    parameter int  FRAMES = 3,
    localparam int AW     = clog2(N * FRAMES)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_re,
    input  logic [W-1:0]  wr_im,
    input  logic          go,
    input  logic          ready,
    output logic          START,
    output logic [W-1:0]  DR,
    output logic [W-1:0]  DI,
    output logic          DVAL,
    output logic          busy,
    output logic          done
);

    localparam int            c_words = N * FRAMES;
    localparam logic [AW:0]   c_depth = (AW + 1)'(c_words);

    logic [W-1:0] mem_re_q [0:c_words-1];
    logic [W-1:0] mem_im_q [0:c_words-1];

    feeder_state_e state_q, state_d;
    logic          start_q, start_d;
    logic          dval_q, dval_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  dr_q, dr_d;
    logic [W-1:0]  di_q, di_d;
    // Set once the frame's last sample has been emitted; the following edge
    // closes the frame so the last sample gets its own display cycle.
    logic          frame_end_q, frame_end_d;

    logic          clr, adv_idx, adv_frame;
    logic          last_idx, last_frame;
    logic [AW-1:0] rd_addr;
    logic          wr_ok;

    fft_feeder_addr_gen #(
        .N      (N),
        .FRAMES (FRAMES),
        .AW     (AW)
    ) u_addr_gen (
        .CLK        (CLK),
        .RST        (RST),
        .clr        (clr),
        .adv_idx    (adv_idx),
        .adv_frame  (adv_frame),
        .last_idx   (last_idx),
        .last_frame (last_frame),
        .rd_addr    (rd_addr)
    );

    // Buffer is frozen during a run and out-of-range addresses are dropped.
    assign wr_ok = wr_en && !busy_q && ({1'b0, wr_addr} < c_depth);

    // Host write port; contents survive reset.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem_re_q[wr_addr] <= wr_re;
            mem_im_q[wr_addr] <= wr_im;
        end
    end

    // Next state and next output values; ready gates only sample emission.
    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        dval_d      = 1'b0;
        done_d      = 1'b0;
        busy_d      = busy_q;
        dr_d        = dr_q;
        di_d        = di_q;
        frame_end_d = frame_end_q;
        clr         = 1'b0;
        adv_idx     = 1'b0;
        adv_frame   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d     = SOF;
                    start_d     = 1'b1;
                    busy_d      = 1'b1;
                    clr         = 1'b1;
                    frame_end_d = 1'b0;
                end
            end
            SOF: begin
                state_d = STREAM;
                if (ready) begin
                    dr_d        = mem_re_q[rd_addr];
                    di_d        = mem_im_q[rd_addr];
                    dval_d      = 1'b1;
                    adv_idx     = 1'b1;
                    frame_end_d = last_idx;
                end
            end
            STREAM: begin
                if (frame_end_q) begin
                    frame_end_d = 1'b0;
                    if (last_frame) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d   = SOF;
                        start_d   = 1'b1;
                        adv_frame = 1'b1;
                    end
                end else if (ready) begin
                    dr_d        = mem_re_q[rd_addr];
                    di_d        = mem_im_q[rd_addr];
                    dval_d      = 1'b1;
                    adv_idx     = 1'b1;
                    frame_end_d = last_idx;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            dval_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dr_q        <= '0;
            di_q        <= '0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            dval_q      <= dval_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dr_q        <= dr_d;
            di_q        <= di_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign START = start_q;
    assign DVAL  = dval_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign DR    = dr_q;
    assign DI    = di_q;

endmodule
`default_nettype wire
